// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped 8N1 UART: register offsets,
// STATUS bit positions, FSM state types and the divisor clamp helper.
package uart_pkg;

    localparam logic [3:0] UART_TXDATA  = 4'h0;
    localparam logic [3:0] UART_RXDATA  = 4'h4;
    localparam logic [3:0] UART_STATUS  = 4'h8;
    localparam logic [3:0] UART_BAUDDIV = 4'hC;

    localparam int ST_TX_BUSY  = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_RX_FERR  = 2;
    localparam int ST_RX_OVR   = 3;
    localparam int ST_TX_OVF   = 4;

    localparam logic [15:0] UART_MIN_DIV = 16'd7;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < UART_MIN_DIV) ? UART_MIN_DIV : v;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, start-edge detect, mid-bit sampling FSM.
// done_o pulses for one clock after the stop-bit sample, with data_o/stop_o valid.
module uart_rx_core
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_i,
    input  logic [15:0] div_i,
    output logic        done_o,
    output logic [7:0]  data_o,
    output logic        stop_o
);

    logic [1:0]  sync_q;
    logic        prev_q;
    rx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        done_q, done_d;
    logic        stop_q, stop_d;
    logic        rx_s;
    logic [15:0] half_m1;

    assign rx_s = sync_q[1];
    // (div+1)/2 - 1, written without a 17-bit intermediate
    assign half_m1 = {1'b0, div_q[15:1]} + {15'b0, div_q[0]} - 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        stop_d  = stop_q;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                    div_d   = div_i;
                end
            end
            RX_START: begin
                if (cnt_q == half_m1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == div_q) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == div_q) begin
                    done_d  = 1'b1;
                    stop_d  = rx_s;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            div_q   <= UART_MIN_DIV;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            stop_q  <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            stop_q  <= stop_d;
        end
    end

    assign done_o = done_q;
    assign data_o = shift_q;
    assign stop_o = stop_q;

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART slave: register file, decode and transmitter FSM.
// Define UART_RX_EN to build the receiver (uart_rx_core) and STATUS bits [3:1].
module uart_peripheral
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Sel,
    input  logic [3:0]            Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] ReadData,
    input  logic                  uart_rx,
    output logic                  uart_tx
);

    localparam logic [15:0] BAUD_RST = 16'(CLKS_PER_BIT - 1);

    logic        wr_en, wr_tx, wr_status, wr_baud;
    logic [3:0]  reg_off;
    logic [15:0] baud_q, baud_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        tx_busy, tx_bit_end;
    logic        rx_valid, rx_ferr, rx_ovr;
    logic [7:0]  rx_byte;
    logic [31:0] status_w;
    logic        unused_bits;

    assign reg_off   = {Address[3:2], 2'b00};
    assign wr_en     = Sel & MemWrite;
    assign wr_tx     = wr_en && (reg_off == UART_TXDATA);
    assign wr_status = wr_en && (reg_off == UART_STATUS);
    assign wr_baud   = wr_en && (reg_off == UART_BAUDDIV);
    assign unused_bits = ^{WriteData[DATA_WIDTH-1:16], Address[1:0]};

    assign tx_busy    = (tx_state_q != TX_IDLE);
    assign tx_bit_end = (tx_cnt_q == tx_div_q);
    assign baud_d     = wr_baud ? clamp_div(WriteData[15:0]) : baud_q;
    // hardware set wins over a same-cycle W1C clear
    assign tx_ovf_d   = (tx_ovf_q & ~(wr_status & WriteData[ST_TX_OVF])) | (wr_tx & tx_busy);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (wr_tx) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_div_d   = baud_q;
                    tx_shift_d = WriteData[7:0];
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) tx_state_d = TX_IDLE;
                else            tx_cnt_d   = tx_cnt_q + 16'd1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_q     <= BAUD_RST;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= BAUD_RST;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_ovf_q   <= 1'b0;
        end else begin
            baud_q     <= baud_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_ovf_q   <= tx_ovf_d;
        end
    end

    assign uart_tx = tx_q;

`ifdef UART_RX_EN
    logic       rx_done, rx_stop;
    logic [7:0] rx_data;
    logic       rx_valid_q, rx_ferr_q, rx_ovr_q;
    logic [7:0] rx_byte_q;
    logic [3:1] clr;

    uart_rx_core u_rx (
        .clk    (clk),
        .reset  (reset),
        .rx_i   (uart_rx),
        .div_i  (baud_q),
        .done_o (rx_done),
        .data_o (rx_data),
        .stop_o (rx_stop)
    );

    assign clr = wr_status ? WriteData[3:1] : 3'b000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            rx_valid_q <= (rx_valid_q & ~clr[ST_RX_VALID]) | rx_done;
            rx_ferr_q  <= (rx_ferr_q & ~clr[ST_RX_FERR]) | (rx_done & ~rx_stop);
            rx_ovr_q   <= (rx_ovr_q & ~clr[ST_RX_OVR]) | (rx_done & rx_valid_q);
            if (rx_done) rx_byte_q <= rx_data;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_ferr  = rx_ferr_q;
    assign rx_ovr   = rx_ovr_q;
    assign rx_byte  = rx_byte_q;
`else
    logic unused_rx;
    assign unused_rx = uart_rx;
    assign rx_valid  = 1'b0;
    assign rx_ferr   = 1'b0;
    assign rx_ovr    = 1'b0;
    assign rx_byte   = 8'h00;
`endif

    always_comb begin
        status_w              = '0;
        status_w[ST_TX_BUSY]  = tx_busy;
        status_w[ST_RX_VALID] = rx_valid;
        status_w[ST_RX_FERR]  = rx_ferr;
        status_w[ST_RX_OVR]   = rx_ovr;
        status_w[ST_TX_OVF]   = tx_ovf_q;
    end

    always_comb begin
        ReadData = '0;
        if (Sel) begin
            case (reg_off)
                UART_RXDATA:  ReadData = {24'b0, rx_byte};
                UART_STATUS:  ReadData = status_w;
                UART_BAUDDIV: ReadData = {16'b0, baud_q};
                default:      ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_peripheral.sv
// Directed bench for uart_peripheral: register vector table, then TX/RX/reset sequences.
// RX checks adapt to whether UART_RX_EN is defined.
module tb_uart_peripheral;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Sel = 1'b0;
    logic [3:0]  Address = 4'h0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] ReadData;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int n_checks = 0;
    int n_fail   = 0;

    uart_peripheral #(.DATA_WIDTH(32), .CLKS_PER_BIT(434)) dut (
        .clk       (clk),
        .reset     (reset),
        .Sel       (Sel),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic        wsel;
        logic        rsel;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[%0t] FAIL %s: got 0x%0h, want 0x%0h", $time, name, act, exp);
        end else begin
            $display("[%0t] ok   %s: 0x%0h", $time, name, act);
        end
    endtask

    // Call at a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic sel, input logic [3:0] a, input logic [31:0] d);
        Sel = sel; Address = a; WriteData = d; MemWrite = 1'b1;
        @(negedge clk);
        Sel = 1'b0; MemWrite = 1'b0; WriteData = '0;
    endtask

    task automatic bus_read(input logic sel, input logic [3:0] a, output logic [31:0] d);
        Sel = sel; Address = a;
        #1;
        d = ReadData;
        Sel = 1'b0;
    endtask

    // Watches one 80-clock frame (8 clocks per bit) starting at the current falling edge.
    task automatic capture(input logic [7:0] b, input bit probe, input string tag);
        logic [9:0] frame, first_s, last_s;
        int busy_cnt;
        frame = {1'b1, b, 1'b0};
        first_s = '0; last_s = '0; busy_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (probe) begin Sel = 1'b1; Address = 4'h8; end
            #1;
            if (i % 8 == 0) first_s[i / 8] = uart_tx;
            if (i % 8 == 7) last_s[i / 8]  = uart_tx;
            if (probe && ReadData[0]) busy_cnt++;
            if (probe) Sel = 1'b0;
            @(negedge clk);
        end
        check({tag, "_bit_start"}, {22'b0, first_s}, {22'b0, frame});
        check({tag, "_bit_end"}, {22'b0, last_s}, {22'b0, frame});
        if (probe) begin
            Sel = 1'b1; Address = 4'h8;
            #1;
            check({tag, "_busy_after"}, {31'b0, ReadData[0]}, 32'd0);
            check({tag, "_line_after"}, {31'b0, uart_tx}, 32'd1);
            check({tag, "_busy_clocks"}, busy_cnt, 32'd80);
            Sel = 1'b0;
        end
    endtask

`ifdef UART_RX_EN
    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx = f[k];
            repeat (8) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int lows;

        vecs[0]  = '{"rst_status",   1'b0, 1'b0, 1'b1, 4'h8, 32'h0,         32'h0};
        vecs[1]  = '{"rst_bauddiv",  1'b0, 1'b0, 1'b1, 4'hC, 32'h0,         32'd433};
        vecs[2]  = '{"rst_txdata",   1'b0, 1'b0, 1'b1, 4'h0, 32'h0,         32'h0};
        vecs[3]  = '{"rst_rxdata",   1'b0, 1'b0, 1'b1, 4'h4, 32'h0,         32'h0};
        vecs[4]  = '{"nosel_read",   1'b0, 1'b0, 1'b0, 4'hC, 32'h0,         32'h0};
        vecs[5]  = '{"clamp_2",      1'b1, 1'b1, 1'b1, 4'hC, 32'd2,         32'd7};
        vecs[6]  = '{"baud_upper",   1'b1, 1'b1, 1'b1, 4'hC, 32'h000F_0009, 32'd9};
        vecs[7]  = '{"nosel_write",  1'b1, 1'b0, 1'b1, 4'hC, 32'd100,       32'd9};
        vecs[8]  = '{"clamp_6",      1'b1, 1'b1, 1'b1, 4'hC, 32'd6,         32'd7};
        vecs[9]  = '{"status_w1c",   1'b1, 1'b1, 1'b1, 4'h8, 32'h1F,        32'h0};
        vecs[10] = '{"addr_lowbits", 1'b1, 1'b1, 1'b1, 4'hE, 32'd7,         32'd7};
        vecs[11] = '{"txdata_read",  1'b0, 1'b0, 1'b1, 4'h3, 32'h0,         32'h0};

        repeat (3) @(negedge clk);
        check("rst_line", {31'b0, uart_tx}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            if (vecs[v].wr) bus_write(vecs[v].wsel, vecs[v].addr, vecs[v].wdata);
            bus_read(vecs[v].rsel, vecs[v].addr, rd);
            check(vecs[v].name, rd, vecs[v].exp);
        end

        // Plain transmit of 0xA5 with busy probed every clock.
        @(negedge clk);
        bus_write(1'b1, 4'h0, 32'hA5);
        capture(8'hA5, 1'b1, "tx_a5");

        // A second write mid-frame is dropped and raises tx_ovf.
        @(negedge clk);
        bus_write(1'b1, 4'h0, 32'hC3);
        fork
            capture(8'hC3, 1'b0, "tx_c3");
            begin
                repeat (20) @(negedge clk);
                bus_write(1'b1, 4'h0, 32'h55);
                bus_read(1'b1, 4'h8, rd);
                check("drop_status_mid", rd, 32'h11);
            end
        join
        bus_read(1'b1, 4'h8, rd);
        check("drop_status_end", rd, 32'h10);
        @(negedge clk);
        bus_write(1'b1, 4'h8, 32'h10);
        bus_read(1'b1, 4'h8, rd);
        check("ovf_cleared", rd, 32'h0);

        // Write landing on the edge that ends the stop bit is dropped.
        @(negedge clk);
        bus_write(1'b1, 4'h0, 32'h0F);
        repeat (79) @(negedge clk);
        bus_read(1'b1, 4'h8, rd);
        check("stop_edge_busy", rd, 32'h01);
        bus_write(1'b1, 4'h0, 32'h77);
        bus_read(1'b1, 4'h8, rd);
        check("stop_edge_status", rd, 32'h10);
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (uart_tx !== 1'b1) lows++;
        end
        check("stop_edge_idle", lows, 32'd0);
        @(negedge clk);
        bus_write(1'b1, 4'h8, 32'h1F);

`ifdef UART_RX_EN
        rx_send(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        bus_read(1'b1, 4'h4, rd);
        check("rx_data_3c", rd, 32'h3C);
        bus_read(1'b1, 4'h8, rd);
        check("rx_valid_set", rd, 32'h02);
        @(negedge clk);
        bus_write(1'b1, 4'h8, 32'h02);
        bus_read(1'b1, 4'h8, rd);
        check("rx_valid_clr", rd, 32'h0);

        @(negedge clk);
        rx_send(8'h81, 1'b0);
        repeat (4) @(negedge clk);
        rx_send(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        bus_read(1'b1, 4'h8, rd);
        check("rx_err_flags", rd, 32'h0E);
        bus_read(1'b1, 4'h4, rd);
        check("rx_overwrite", rd, 32'h5A);

        @(negedge clk);
        bus_write(1'b1, 4'h8, 32'h1F);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (100) @(negedge clk);
        bus_read(1'b1, 4'h8, rd);
        check("rx_glitch", rd, 32'h0);
`else
        for (int k = 0; k < 10; k++) begin
            uart_rx = (k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : k[0]);
            repeat (8) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(1'b1, 4'h4, rd);
        check("norx_rxdata", rd, 32'h0);
        bus_read(1'b1, 4'h8, rd);
        check("norx_status", rd, 32'h0);
`endif

        // Asynchronous reset in the middle of a low data bit.
        @(negedge clk);
        bus_write(1'b1, 4'h0, 32'h00);
        repeat (12) @(negedge clk);
        bus_write(1'b1, 4'h0, 32'h11);
        #2;
        check("pre_reset_line", {31'b0, uart_tx}, 32'd0);
        reset = 1'b0;
        #1;
        check("async_reset_line", {31'b0, uart_tx}, 32'd1);
        Sel = 1'b1; Address = 4'h8;
        #1;
        check("reset_status", ReadData, 32'h0);
        Address = 4'hC;
        #1;
        check("reset_bauddiv", ReadData, 32'd433);
        Sel = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(1'b1, 4'h8, rd);
        check("post_reset_idle", {rd[31:1], uart_tx}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
